// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared types, widths, segment patterns and the double-dabble step
package bcd_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 10;
  localparam int SCRATCH_W  = 26;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // One shift-add-3 iteration: correct every BCD nibble that would overflow
  // past 9 after doubling, then shift the whole scratch register left.
  function automatic logic [SCRATCH_W-1:0] dabble_step(input logic [SCRATCH_W-1:0] s);
    logic [SCRATCH_W-1:0] t;
    t = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
        t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    return {t[SCRATCH_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD digit to active-low 7-segment pattern with blank override
module seg7_decoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Blank flag wins; codes 10..15 light nothing
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_controller.sv
// rtl/bcd_display_controller.sv - periodic binary-to-BCD conversion and multiplexed 7-segment scan
module bcd_display_controller
  import bcd_display_pkg::*;
#(
  parameter int SAMPLE_DIV = 5_000_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_ones,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_hundreds,
  output logic [3:0]       o_thousands,
  output logic [3:0]       o_an,
  output logic [6:0]       o_seg
);

  localparam int SAMPLE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SAMPLE_W-1:0]  r_sample_cnt;
  logic                 w_tick;
  logic                 w_trigger;

  state_t               r_state;
  logic [SCRATCH_W-1:0] r_scratch;
  logic [3:0]           r_bit_cnt;
  logic                 r_pending;
  logic                 r_busy;
  logic                 r_done;
  logic [3:0]           r_ones;
  logic [3:0]           r_tens;
  logic [3:0]           r_hundreds;
  logic [3:0]           r_thousands;

  logic [SCAN_W-1:0]    r_scan_cnt;
  logic [1:0]           r_digit_idx;
  logic [3:0]           r_an;
  logic [6:0]           r_seg;
  logic [1:0]           w_next_idx;
  logic [3:0]           w_next_digit;
  logic                 w_next_blank;
  logic [6:0]           w_next_seg;

  assign w_tick    = (r_sample_cnt == SAMPLE_W'(SAMPLE_DIV - 1));
  assign w_trigger = w_tick | i_start;

  // Free-running sample timer; its wrap cycle is the automatic trigger
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sample_cnt <= '0;
    end else if (w_tick) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + SAMPLE_W'(1);
    end
  end

  // Conversion FSM: capture, ten shift-add-3 steps, then latch digits.
  // Triggers arriving while busy collapse into a single pending request.
  // busy lags the state by one edge so it stays high through the done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_scratch   <= '0;
      r_bit_cnt   <= '0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ones      <= '0;
      r_tens      <= '0;
      r_hundreds  <= '0;
      r_thousands <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_trigger || r_pending) begin
            r_scratch <= {{(SCRATCH_W-BIN_W){1'b0}}, i_value};
            r_bit_cnt <= '0;
            r_pending <= 1'b0;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_scratch <= dabble_step(r_scratch);
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'(BIN_W - 1)) begin
            r_state <= ST_LATCH;
          end
          if (w_trigger) begin
            r_pending <= 1'b1;
          end
        end
        ST_LATCH: begin
          {r_thousands, r_hundreds, r_tens, r_ones} <= r_scratch[SCRATCH_W-1:BIN_W];
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          if (w_trigger) begin
            r_pending <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Select the digit that becomes active at the next scan wrap and decide
  // whether it is a leading zero
  always_comb begin
    w_next_idx   = r_digit_idx + 2'd1;
    w_next_digit = r_ones;
    w_next_blank = 1'b0;
    case (w_next_idx)
      2'd0: begin
        w_next_digit = r_ones;
        w_next_blank = 1'b0;
      end
      2'd1: begin
        w_next_digit = r_tens;
        w_next_blank = (r_thousands == 4'd0) && (r_hundreds == 4'd0) && (r_tens == 4'd0);
      end
      2'd2: begin
        w_next_digit = r_hundreds;
        w_next_blank = (r_thousands == 4'd0) && (r_hundreds == 4'd0);
      end
      default: begin
        w_next_digit = r_thousands;
        w_next_blank = (r_thousands == 4'd0);
      end
    endcase
  end

  seg7_decoder u_decoder (
    .i_digit (w_next_digit),
    .i_blank (w_next_blank),
    .o_seg   (w_next_seg)
  );

  // Scan: anode and segment registers update together on each scan wrap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
      r_an        <= 4'b1110;
      r_seg       <= SEG_0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= w_next_idx;
      r_an        <= ~(4'b0001 << w_next_idx);
      r_seg       <= w_next_seg;
    end else begin
      r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ones      = r_ones;
  assign o_tens      = r_tens;
  assign o_hundreds  = r_hundreds;
  assign o_thousands = r_thousands;
  assign o_an        = r_an;
  assign o_seg       = r_seg;

endmodule
